// File: rtl/mips_pkg.sv
// Shared constants, ALU operation encoding and SEC-DED position helpers
// for the pipelined MIPS-subset core.
package mips_pkg;

    localparam int ECC_DW = 32;
    localparam int ECC_PW = 7;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL
    } alu_op_e;

    // Codeword position (1..38) of data bit idx: the non-power-of-two slots in order.
    function automatic logic [5:0] ecc_pos(input int idx);
        int cnt;
        logic [5:0] res;
        cnt = 0;
        res = '0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = 6'(p);
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [5:0] ecc_hp(input logic [ECC_DW-1:0] d);
        logic [5:0] hp;
        logic [5:0] pos;
        hp = '0;
        for (int i = 0; i < ECC_DW; i++) begin
            pos = ecc_pos(i);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) hp[k] = hp[k] ^ d[i];
            end
        end
        return hp;
    endfunction

endpackage

// File: rtl/ecc_secded.sv
// SEC-DED (38,32)+overall-parity codec: p_o encodes data_i; data_o/flags decode {data_i, p_i}.
module ecc_secded
    import mips_pkg::*;
(
    input  logic [ECC_DW-1:0] data_i,
    input  logic [ECC_PW-1:0] p_i,
    output logic [ECC_PW-1:0] p_o,
    output logic [ECC_DW-1:0] data_o,
    output logic              single_err_o,
    output logic              double_err_o
);

    logic [5:0] hp;
    logic [5:0] syn;
    logic       ovr;

    assign hp  = ecc_hp(data_i);
    assign p_o = {^{data_i, hp}, hp};
    assign syn = hp ^ p_i[5:0];
    assign ovr = ^{data_i, p_i};

    // A check-bit syndrome matches no data position, so only data hits get flipped.
    always_comb begin
        data_o       = data_i;
        single_err_o = 1'b0;
        double_err_o = 1'b0;
        if (ovr) begin
            single_err_o = 1'b1;
            for (int i = 0; i < ECC_DW; i++) begin
                if (ecc_pos(i) == syn) data_o[i] = ~data_i[i];
            end
        end else if (syn != '0) begin
            double_err_o = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_mips.sv
// Five-stage MIPS-subset core with forwarding, lw-use stall and an
// ECC-protected data memory shared with a user port and a fault-injection port.
module pipeline_mips
    import mips_pkg::*;
#(
    parameter int DMEM_AW = 9,
    parameter int USER_AW = 13
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         pc,
    input  logic [31:0]         instruction,
    input  logic [USER_AW-1:0]  user_addr,
    input  logic                user_we,
    input  logic [31:0]         user_din,
    output logic [31:0]         user_dout,
    input  logic                error_dwe,
    input  logic                error_pwe,
    input  logic [31:0]         error_din,
    input  logic [6:0]          error_pin,
    input  logic [DMEM_AW-1:0]  error_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_pc_q;
    logic [31:0] idex_instr_q, idex_pc_q, idex_a_q, idex_b_q;
    logic [4:0]  exmem_rd_q;
    logic        exmem_lw_q, exmem_sw_q;
    logic [31:0] exmem_alu_q, exmem_sd_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_val_q;
    logic [31:0] rf_q [32];
    logic [38:0] dmem [0:(1<<DMEM_AW)-1];

    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest;
    logic [31:0] id_a, id_b, jump_pc, branch_pc, alu_res;
    logic        stall, id_jump, ex_lw, ex_sw, ex_beq, use_imm, branch_taken;
    logic signed [31:0] fa, fb, ex_imm, alu_b;
    alu_op_e     alu_op;

    assign pc = pc_q;

    // ID: register read with same-cycle WB bypass, jump and lw-use detection
    assign id_rs   = ifid_instr_q[25:21];
    assign id_rt   = ifid_instr_q[20:16];
    assign id_jump = (ifid_instr_q[31:26] == OP_J);
    assign jump_pc = {4'b0, ifid_instr_q[25:0], 2'b00} | ((ifid_pc_q + 32'd4) & 32'hF000_0000);
    assign stall   = (idex_instr_q[31:26] == OP_LW) && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        id_a = rf_q[id_rs];
        id_b = rf_q[id_rt];
        if (id_rs == 5'd0)             id_a = '0;
        else if (memwb_rd_q == id_rs)  id_a = memwb_val_q;
        if (id_rt == 5'd0)             id_b = '0;
        else if (memwb_rd_q == id_rt)  id_b = memwb_val_q;
    end

    // EX: forwarding, decode and ALU; beq resolves here
    assign ex_rs  = idex_instr_q[25:21];
    assign ex_rt  = idex_instr_q[20:16];
    assign ex_imm = {{16{idex_instr_q[15]}}, idex_instr_q[15:0]};

    always_comb begin
        fa = idex_a_q;
        fb = idex_b_q;
        if (ex_rs != 5'd0 && ex_rs == exmem_rd_q && !exmem_lw_q) fa = exmem_alu_q;
        else if (ex_rs != 5'd0 && ex_rs == memwb_rd_q)           fa = memwb_val_q;
        if (ex_rt != 5'd0 && ex_rt == exmem_rd_q && !exmem_lw_q) fb = exmem_alu_q;
        else if (ex_rt != 5'd0 && ex_rt == memwb_rd_q)           fb = memwb_val_q;
    end

    always_comb begin
        alu_op  = ALU_NOP;
        ex_dest = 5'd0;
        ex_lw   = 1'b0;
        ex_sw   = 1'b0;
        ex_beq  = 1'b0;
        use_imm = 1'b0;
        case (idex_instr_q[31:26])
            OP_RTYPE: begin
                ex_dest = idex_instr_q[15:11];
                case (idex_instr_q[5:0])
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    default: ex_dest = 5'd0;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; ex_dest = ex_rt; end
            OP_LW:   begin alu_op = ALU_ADD; use_imm = 1'b1; ex_dest = ex_rt; ex_lw = 1'b1; end
            OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; ex_sw = 1'b1; end
            OP_BEQ:  ex_beq = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = use_imm ? ex_imm : fb;

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_res = fa + alu_b;
            ALU_SUB: alu_res = fa - alu_b;
            ALU_AND: alu_res = fa & alu_b;
            ALU_OR:  alu_res = fa | alu_b;
            ALU_SLT: alu_res = {31'd0, (fa < alu_b)};
            ALU_SLL: alu_res = fb << idex_instr_q[10:6];
            default: alu_res = '0;
        endcase
    end

    assign branch_taken = ex_beq && (fa == fb);
    assign branch_pc    = idex_pc_q + 32'd4 + {ex_imm[29:0], 2'b00};

    always_comb begin
        if (branch_taken) pc_d = branch_pc;
        else if (stall)   pc_d = pc_q;
        else if (id_jump) pc_d = jump_pc;
        else              pc_d = pc_q + 32'd4;
    end

    // MEM: decoded load data, plus the encoders feeding the memory writes
    logic [DMEM_AW-1:0] mem_word, usr_word;
    logic [38:0]        mem_rd, usr_rd;
    logic [31:0]        lw_data, usr_data;
    logic [6:0]         sw_p, usr_p;
    logic               usr_ok;
    logic [6:0]         unused_p_lw, unused_p_ud;
    logic [31:0]        unused_d_sw, unused_d_uw;
    logic [7:0]         unused_flags;

    assign mem_word  = exmem_alu_q[DMEM_AW+1:2];
    assign usr_word  = user_addr[DMEM_AW-1:0];
    assign usr_ok    = (user_addr[USER_AW-1:DMEM_AW] == '0);
    assign mem_rd    = dmem[mem_word];
    assign usr_rd    = dmem[usr_word];
    assign user_dout = usr_ok ? usr_data : 32'd0;

    ecc_secded u_dec_lw (.data_i(mem_rd[38:7]), .p_i(mem_rd[6:0]), .p_o(unused_p_lw),
                         .data_o(lw_data), .single_err_o(unused_flags[0]), .double_err_o(unused_flags[1]));
    ecc_secded u_dec_usr (.data_i(usr_rd[38:7]), .p_i(usr_rd[6:0]), .p_o(unused_p_ud),
                          .data_o(usr_data), .single_err_o(unused_flags[2]), .double_err_o(unused_flags[3]));
    ecc_secded u_enc_sw (.data_i(exmem_sd_q), .p_i(7'd0), .p_o(sw_p),
                         .data_o(unused_d_sw), .single_err_o(unused_flags[4]), .double_err_o(unused_flags[5]));
    ecc_secded u_enc_usr (.data_i(user_din), .p_i(7'd0), .p_o(usr_p),
                          .data_o(unused_d_uw), .single_err_o(unused_flags[6]), .double_err_o(unused_flags[7]));

    // Later assignments win on the same word: injection > user > sw.
    always_ff @(posedge clk) begin
        if (exmem_sw_q)       dmem[mem_word] <= {exmem_sd_q, sw_p};
        if (user_we && usr_ok) dmem[usr_word] <= {user_din, usr_p};
        if (error_dwe)        dmem[error_addr][38:7] <= error_din;
        if (error_pwe)        dmem[error_addr][6:0]  <= error_pin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            idex_instr_q <= NOP;
            idex_pc_q    <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            exmem_rd_q   <= '0;
            exmem_lw_q   <= 1'b0;
            exmem_sw_q   <= 1'b0;
            exmem_alu_q  <= '0;
            exmem_sd_q   <= '0;
            memwb_rd_q   <= '0;
            memwb_val_q  <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q        <= pc_d;
            exmem_rd_q  <= ex_dest;
            exmem_lw_q  <= ex_lw;
            exmem_sw_q  <= ex_sw;
            exmem_alu_q <= alu_res;
            exmem_sd_q  <= fb;
            memwb_rd_q  <= exmem_rd_q;
            memwb_val_q <= exmem_lw_q ? lw_data : exmem_alu_q;
            if (memwb_rd_q != 5'd0) rf_q[memwb_rd_q] <= memwb_val_q;
            if (branch_taken || stall) begin
                idex_instr_q <= NOP;
                idex_pc_q    <= '0;
                idex_a_q     <= '0;
                idex_b_q     <= '0;
            end else begin
                idex_instr_q <= ifid_instr_q;
                idex_pc_q    <= ifid_pc_q;
                idex_a_q     <= id_a;
                idex_b_q     <= id_b;
            end
            if (branch_taken || (id_jump && !stall)) begin
                ifid_instr_q <= NOP;
                ifid_pc_q    <= '0;
            end else if (!stall) begin
                ifid_instr_q <= instruction;
                ifid_pc_q    <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mips.sv
// Directed bench for pipeline_mips: reset, user port, forwarding/stall,
// ECC correction paths, write priority and control flow.
module tb_pipeline_mips;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [12:0] user_addr = '0;
    logic        user_we = 1'b0;
    logic [31:0] user_din = '0;
    logic [31:0] user_dout;
    logic        error_dwe = 1'b0;
    logic        error_pwe = 1'b0;
    logic [31:0] error_din = '0;
    logic [6:0]  error_pin = '0;
    logic [8:0]  error_addr = '0;

    logic [31:0] imem [0:63];
    int n_cmp = 0;
    int n_bad = 0;
    int stalls;

    always #5 clk = ~clk;

    assign instruction = (pc[31:8] == 24'd0) ? imem[pc[7:2]] : 32'h0;

    pipeline_mips dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
        .user_addr(user_addr), .user_we(user_we), .user_din(user_din), .user_dout(user_dout),
        .error_dwe(error_dwe), .error_pwe(error_pwe), .error_din(error_din),
        .error_pin(error_pin), .error_addr(error_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic user_wr(input logic [12:0] a, input logic [31:0] d);
        user_addr = a; user_din = d; user_we = 1'b1;
        @(negedge clk);
        user_we = 1'b0;
    endtask

    task automatic user_rd(input string tag, input logic [12:0] a, input logic [31:0] exp);
        user_addr = a;
        #1;
        chk(tag, user_dout, exp);
    endtask

    task automatic inject(input logic dwe, input logic pwe, input logic [8:0] a,
                          input logic [31:0] d, input logic [6:0] p);
        error_dwe = dwe; error_pwe = pwe; error_addr = a; error_din = d; error_pin = p;
        @(negedge clk);
        error_dwe = 1'b0; error_pwe = 1'b0;
    endtask

    task automatic run_prog(input int cycles, output int n_stall);
        logic [31:0] prev;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev = pc;
        n_stall = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pc == prev) n_stall++;
            prev = pc;
        end
    endtask

    initial begin
        clr_imem();
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        rst = 1'b0;
        @(negedge clk); chk("pc_4", pc, 32'd4);
        @(negedge clk); chk("pc_8", pc, 32'd8);
        @(negedge clk); chk("pc_12", pc, 32'd12);

        user_wr(13'd5, 32'd42);
        user_rd("user_rd5", 13'd5, 32'd42);
        user_wr(13'h205, 32'h55);
        user_rd("hi_wr_ignored", 13'd5, 32'd42);
        user_rd("hi_rd_zero", 13'h205, 32'd0);

        // addi $1,$0,7; sw $1,4($0); lw $2,4($0); add $3,$2,$2; sw $3,8($0)
        clr_imem();
        imem[0] = 32'h2001_0007;
        imem[1] = 32'hAC01_0004;
        imem[2] = 32'h8C02_0004;
        imem[3] = 32'h0042_1820;
        imem[4] = 32'hAC03_0008;
        run_prog(15, stalls);
        chk("fwd_stalls", stalls, 32'd1);
        user_rd("fwd_mem1", 13'd1, 32'd7);
        user_rd("fwd_mem2", 13'd2, 32'd14);

        // 2 encodes to p=7'h45; raw data 3 is a single-bit error at position 3
        user_wr(13'd1, 32'd2);
        inject(1'b1, 1'b0, 9'd1, 32'd3, 7'd0);
        user_rd("sec_user", 13'd1, 32'd2);
        clr_imem();
        imem[0] = 32'h8C04_0004;
        imem[1] = 32'hAC04_0010;
        run_prog(12, stalls);
        user_rd("sec_lw", 13'd4, 32'd2);

        // 14 encodes to p=7'h04; flip p0
        inject(1'b0, 1'b1, 9'd2, 32'd0, 7'h05);
        user_rd("chkbit_err", 13'd2, 32'd14);

        // 0 encodes to p=0; flip data bit 0 and p1 -> double error, raw data back
        user_wr(13'd3, 32'd0);
        inject(1'b1, 1'b1, 9'd3, 32'd1, 7'h02);
        user_rd("double_err", 13'd3, 32'd1);

        user_addr = 13'd6; user_din = 32'h100; user_we = 1'b1;
        error_addr = 9'd6; error_din = 32'h200; error_dwe = 1'b1;
        @(negedge clk);
        user_we = 1'b0; error_dwe = 1'b0;
        user_rd("prio_err_over_user", 13'd6, 32'h200);

        user_addr = 13'd7; user_din = 32'h77; user_we = 1'b1;
        error_addr = 9'd8; error_din = 32'h99; error_dwe = 1'b1;
        @(negedge clk);
        user_we = 1'b0; error_dwe = 1'b0;
        user_rd("diff_word_user", 13'd7, 32'h77);

        // beq skips words 2-3, j skips 5-6; then sll/sub/slt/or/and chain
        clr_imem();
        imem[0]  = 32'h2005_0001;
        imem[1]  = 32'h1000_0002;
        imem[2]  = 32'h20A5_0010;
        imem[3]  = 32'h20A5_0020;
        imem[4]  = 32'h0800_0007;
        imem[5]  = 32'h20A5_0040;
        imem[6]  = 32'h20A5_0080;
        imem[7]  = 32'h0005_3080;
        imem[8]  = 32'h0006_3822;
        imem[9]  = 32'h00E0_402A;
        imem[10] = 32'h0106_4825;
        imem[11] = 32'h00E9_5024;
        imem[12] = 32'hAC05_0028;
        imem[13] = 32'hAC09_002C;
        imem[14] = 32'hAC0A_0030;
        imem[15] = 32'hAC07_0034;
        run_prog(30, stalls);
        user_rd("ctl_flush", 13'd10, 32'd1);
        user_rd("ctl_or", 13'd11, 32'd5);
        user_rd("ctl_and", 13'd12, 32'd4);
        user_rd("ctl_sub", 13'd13, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
